// File: rtl/dm_access_ctrl.sv
// MEM-stage data memory access controller: handshake sequencing,
// alignment checking, store lane replication and load extension.
module dm_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic              align_err,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [3:0]        m_be,
  output logic [31:0]       m_wdata,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata,
  input  logic              m_rvalid
);

  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LHU = 3'd2;
  localparam logic [2:0] LD_LB  = 3'd3;
  localparam logic [2:0] LD_LBU = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RD,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        ld_q, ld_d;
  logic [1:0]        off_q, off_d;

  logic        is_half, is_byte, misal;
  logic [31:0] rep_data;
  logic [31:0] lane;
  logic [15:0] half;
  logic [31:0] ext_data;

  // Stores size from byte enables; loads size from the load type.
  always_comb begin
    is_half = 1'b0;
    is_byte = 1'b0;
    if (mem_write) begin
      case (be)
        4'b0011, 4'b1100: is_half = 1'b1;
        4'b0001, 4'b0010,
        4'b0100, 4'b1000: is_byte = 1'b1;
        default: ;
      endcase
    end else begin
      is_half = (ld_type == LD_LH) || (ld_type == LD_LHU);
      is_byte = (ld_type == LD_LB) || (ld_type == LD_LBU);
    end
    if (is_byte)      misal = 1'b0;
    else if (is_half) misal = addr[0];
    else              misal = |addr[1:0];
  end

  always_comb begin
    if (is_byte)      rep_data = {4{wdata[7:0]}};
    else if (is_half) rep_data = {2{wdata[15:0]}};
    else              rep_data = wdata;
  end

  always_comb begin
    lane = m_rdata >> {off_q, 3'b000};
    half = off_q[1] ? m_rdata[31:16] : m_rdata[15:0];
    case (ld_q)
      LD_LH:   ext_data = {{16{half[15]}}, half};
      LD_LHU:  ext_data = {16'h0, half};
      LD_LB:   ext_data = {{24{lane[7]}}, lane[7:0]};
      LD_LBU:  ext_data = {24'h0, lane[7:0]};
      default: ext_data = m_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ld_d        = ld_q;
    off_d       = off_q;
    stall       = 1'b0;
    align_err   = 1'b0;
    m_req       = 1'b0;
    rdata_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (misal) begin
            align_err = 1'b1;
          end else begin
            stall   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[ADDR_W-1:2], 2'b00};
            be_d    = mem_write ? be : 4'b1111;
            wdata_d = mem_write ? rep_data : 32'h0;
            ld_d    = ld_type;
            off_d   = addr[1:0];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        m_req = 1'b1;
        stall = 1'b1;
        if (m_ready) begin
          if (we_q) begin
            state_d = DONE;
          end else if (m_rvalid) begin
            rdata_d = ext_data;
            state_d = DONE;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        stall = 1'b1;
        if (m_rvalid) begin
          rdata_d = ext_data;
          state_d = DONE;
        end
      end
      DONE: begin
        rdata_valid = !we_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      ld_q    <= 3'h0;
      off_q   <= 2'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ld_q    <= ld_d;
      off_q   <= off_d;
    end
  end

  assign m_we      = we_q;
  assign m_addr    = addr_q;
  assign m_be      = be_q;
  assign m_wdata   = wdata_q;
  assign rdata_out = rdata_q;

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
- Memory-stage access controller. Sits directly downstream of the store byte-enable generator and upstream of the data memory / bus.
- Takes the MEM-stage address, store data, byte enables and load type. Drives a request/ready/rvalid handshake to a variable-latency data memory.
- Stalls the pipeline until the access completes.
- Returns load data already lane-selected and sign/zero-extended for the MEM/WB register.

Parameters:
- ADDR_W, 32, width of the byte address and of m_addr.

Ports:
- clk  in  1  Pipeline clock; all state changes on its rising edge.
- rst_n  in  1  Synchronous, active-low reset.
- mem_read  in  1  MEM-stage instruction is a load.
- mem_write  in  1  MEM-stage instruction is a store.
- ld_type  in  3  Load type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
- addr  in  ADDR_W  Byte address, i.e. the ALU result.
- be  in  4  Store byte enables from the byte-enable generator.
- wdata  in  32  Raw rt value, right-aligned.
- stall  out  1  Freeze the pipeline.
- align_err  out  1  Misaligned access detected.
- rdata_out  out  32  Extended load result.
- rdata_valid  out  1  One-cycle pulse when rdata_out updates.
- m_req  out  1  Memory request.
- m_we  out  1  Write request.
- m_addr  out  ADDR_W  Word-aligned address: addr with bits [1:0] forced to 0.
- m_be  out  4  Write byte enables; 1111 for reads.
- m_wdata  out  32  Lane-replicated store data.
- m_ready  in  1  Memory accepted the request.
- m_rdata  in  32  Read word.
- m_rvalid  in  1  m_rdata is valid.

Behaviour:
- FSM states: IDLE, REQ, WAIT_RD, DONE.
- Reset: state IDLE; m_req, m_we, rdata_valid, align_err = 0; rdata_out = 0; m_addr, m_be, m_wdata = 0.
- Reset mid-access: abandon the access and go to IDLE. Any later m_rvalid is ignored.
- Alignment check (combinational, IDLE only):
  - LW/store-word: addr[1:0] must be 00.
  - LH/LHU/store-half: addr[0] must be 0.
  - Stores classify width from be: 1111 word, 0011/1100 half, one-hot byte.
- On a misaligned access in IDLE: align_err = 1, stall = 0, no request issued, state stays IDLE.
- Store data replication: word = wdata; half = {2{wdata[15:0]}}; byte = {4{wdata[7:0]}}.
- IDLE with (mem_read | mem_write) and aligned:
  - stall = 1 combinationally.
  - At the edge, latch m_addr, m_we (= mem_write), m_be (be for writes, 1111 for reads), m_wdata, ld_type and addr[1:0]; go to REQ.
  - If both mem_read and mem_write are set, the write wins and no read occurs.
- REQ:
  - m_req = 1, stall = 1. All m_* outputs are held stable until m_ready is sampled high.
  - Write accepted → DONE.
  - Read accepted with m_rvalid = 0 → WAIT_RD.
  - Read accepted with m_rvalid = 1 in the same cycle → capture the data, go to DONE.
- WAIT_RD: m_req = 0, stall = 1. On m_rvalid, capture the extended data into rdata_out and go to DONE.
- DONE:
  - stall = 0, so the pipeline advances at this edge.
  - rdata_valid = 1 for loads only.
  - Unconditionally go to IDLE. Inputs present during DONE are never re-issued.
- Load extension uses the latched addr[1:0]:
  - Byte lane = m_rdata[8*a+7 : 8*a].
  - Halfword = a[1] ? m_rdata[31:16] : m_rdata[15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rdata_out holds its value until the next load completes.
- m_rvalid outside REQ/WAIT_RD is ignored. m_ready outside REQ is ignored.
- Minimum latency with a zero-wait memory (m_ready = 1 in REQ, m_rvalid the next cycle): stall is high for 3 cycles (IDLE, REQ, WAIT_RD) and low in DONE. A store with immediate m_ready stalls for 2 cycles.

Test Plan:
- SB, addr = 0x1002, wdata = 0x000000AB, be = 0100, m_ready immediate → m_req for 1 cycle, m_addr = 0x1000, m_be = 0100, m_wdata = 0xABABABAB, m_we = 1; stall high for 2 cycles, then DONE; rdata_valid stays 0.
- LB, addr = 0x2001, m_rdata = 0x123480FF → rdata_out = 0xFFFFFF80, rdata_valid pulses once. Repeat as LBU → 0x00000080. LH at 0x2002 → 0x00001234.
- LH at addr 0x2003 → align_err = 1 in that cycle, m_req never asserted, stall = 0, rdata_out unchanged.
- SW with m_ready delayed 3 cycles → m_req, m_addr, m_be and m_wdata are held constant for 4 REQ cycles; stall stays high throughout; exactly one DONE cycle.
- LW with m_ready and m_rvalid asserted together (m_rdata = 0xDEADBEEF) → REQ goes directly to DONE, rdata_out = 0xDEADBEEF.
- rst_n = 0 while in WAIT_RD, then m_rvalid arrives after reset is released → FSM in IDLE, stall = 0, rdata_valid = 0, rdata_out = 0.
